order_feed_parser: RTL and testbench
====================================

# order_feed_parser

Upstream stage of `order_book`. Assembles the 11-byte exchange feed message stream into decoded orders, buffers them in a small FIFO, and presents one order at a time to `order_book` on its `i_trade_type`/`i_stock_id`/`i_order_type`/`i_quantity`/`i_price`/`i_order_id` inputs. It holds each order's fields stable for the whole busy window of the book.

## Interface
- `FIFO_DEPTH`, default 4: decoded-order buffer entries (power of 2, ≥2).
- `MSG_BYTES`, default 11: bytes per message (fixed; documented, not for override).
- `i_clk` input 1: clock; everything on rising edge.
- `i_reset_n` input 1: synchronous reset, active-high (asserted = 1); port name matches the book's reset port.
- `i_byte` input 8: feed byte.
- `i_byte_valid` input 1: byte present.
- `i_byte_sof` input 1: marks byte 0 of a message; qualified by valid.
- `o_byte_ready` input-side output 1: byte accepted when valid && ready.
- `i_book_busy` input 1: `order_book.o_book_is_busy`.
- `o_trade_type` output 1; `o_stock_id` output 2; `o_order_type` output 2; `o_quantity` output 16; `o_price` output 32; `o_order_id` output 32: to the book.
- `o_msg_count` output 16: accepted messages, wraps.
- `o_err_count` output 8: framing/format errors, saturates at 255.

## Operation
- Message layout: byte0 = {trade_type[7], stock_id[6:5], order_type[4:3], reserved[2:0]=0}. Bytes 1–2 = quantity, bytes 3–6 = price, bytes 7–10 = order_id. All fields are big-endian.
- Receive FSM: RX_IDLE, RX_BODY, RX_DROP.
  - RX_IDLE: an accepted byte with sof latches the header, sets byte counter to 1, and moves to RX_BODY. An accepted byte without sof increments err and moves to RX_DROP.
  - RX_BODY: accepted bytes shift into the field registers and the counter increments. A sof byte here is a premature restart: err increments, the partial message is discarded, and this byte is treated as a new byte0. On byte 10, the message commits and the FSM returns to RX_IDLE.
  - RX_DROP: non-sof bytes are ignored. A sof byte is handled as in RX_IDLE.
- Commit rules:
  - order_type==3 or reserved≠0: err increments and nothing is written to the FIFO.
  - Otherwise: FIFO push and msg_count increments.
- `o_byte_ready` = !fifo_full. Because of this, a commit never meets a full FIFO.
- Output FSM: OUT_IDLE, OUT_PRESENT, OUT_HOLD.
  - OUT_IDLE: `o_order_type`=2'b11 (book NOP code), other fields 0. If the FIFO is non-empty and `i_book_busy`=0, load the head into the output registers and go to OUT_PRESENT.
  - OUT_PRESENT: hold the fields. When `i_book_busy`=1, go to OUT_HOLD.
  - OUT_HOLD: hold the fields. When `i_book_busy`=0, pop the FIFO, drive NOP, and go to OUT_IDLE.
- Fields never change while in OUT_PRESENT or OUT_HOLD.
- The book consumes only one order per busy window. Back-to-back orders are separated by at least one NOP cycle.

## Timing
- Reset values: `o_byte_ready`=0 during reset, then 1. `o_order_type`=2'b11. All other outputs 0. Both FSMs are in their IDLE states. FIFO is empty. Counters are 0. Partial messages are discarded.
- Reset mid-presentation: the order is lost. The book is reset by the same signal.
- Byte throughput: 1 byte/cycle; a message takes 11 cycles minimum.
- Latency: last byte accepted at edge N gives a FIFO push at N. If the output path is idle and the book is not busy, fields are valid from edge N+1, with no bypass.
- Simultaneous push and pop in the same cycle are both honoured; the count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits plus 1 wrap bit. Full = pointers equal except the MSB; empty = pointers equal.

## Structure
- Shared package `hft_pkg`:
  - `order_t` enum: ADD=0, CANCEL=1, EXECUTE=2, NOP=3.
  - Packed `order_msg_t` struct: trade_type, stock_id, order_type, quantity, price, order_id = 85 bits.
  - MSG_BYTES constant.
- One sub-module: `order_fifo`, a generic synchronous FIFO parameterised on width and depth with push/pop/full/empty.
- The parser contains the RX FSM, field shifter, output FSM and counters.

## Test plan
- Single ADD: bytes 0x00,0x00,0x64,0x00,0x00,0x03,0xE8,0x00,0x00,0x00,0x2A with `i_book_busy` low -> one edge after the last byte: type=0, stock=0, qty=100, price=1000, id=42. Fields hold through busy high, then return to NOP after busy falls. msg_count=1.
- Busy book: hold `i_book_busy`=1 while sending 2 messages -> outputs stay NOP. After release, the orders are presented in order, each held for its own busy window.
- FIFO full: send 5 messages with busy stuck high -> `o_byte_ready` falls after the 4th commit. No byte loss. Release empties the FIFO in order.
- Framing: sof at byte 5 of a message -> err=1. The new message decodes correctly. A stray non-sof byte in RX_IDLE -> err increments and bytes are ignored until the next sof.
- Format: header 0x18 (type 3) and header 0x01 (reserved≠0) -> err+2, no FIFO push, msg_count unchanged.
- Reset asserted at byte 6, then released -> all outputs at reset values, and the next complete message decodes normally.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared types for the exchange feed path: order codes, decoded order record, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: order_t, order_msg_t (85 bits), rx/out FSM state enums, MSG_BYTES, NOP_MSG.
package hft_pkg;

  localparam int MSG_BYTES = 11;

  typedef enum logic [1:0] {
    ADD     = 2'd0,
    CANCEL  = 2'd1,
    EXECUTE = 2'd2,
    NOP     = 2'd3
  } order_t;

  typedef struct packed {
    logic        trade_type;
    logic [1:0]  stock_id;
    order_t      order_type;
    logic [15:0] quantity;
    logic [31:0] price;
    logic [31:0] order_id;
  } order_msg_t;

  // What the book sees when no order is being offered.
  localparam order_msg_t NOP_MSG = '{
    trade_type: 1'b0,
    stock_id:   2'd0,
    order_type: NOP,
    quantity:   16'd0,
    price:      32'd0,
    order_id:   32'd0
  };

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_BODY = 2'd1,
    RX_DROP = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE    = 2'd0,
    OUT_PRESENT = 2'd1,
    OUT_HOLD    = 2'd2
  } out_state_t;

endpackage

// File: rtl/order_fifo.sv
// Generic synchronous FIFO holding decoded orders between the byte parser and the book.
// Latency: a push at edge N is visible on pop_data/empty after edge N; pop_data is a combinational head read.
// Backpressure: full is raised when all DEPTH entries are used; pushes while full and pops while empty are ignored.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data, full, empty.
module order_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/order_feed_parser.sv
// Assembles 11-byte feed messages into orders and offers them one at a time to order_book.
// Latency: last byte accepted at edge N pushes at N; with the output idle and the book not busy, fields are valid from N+1.
// Backpressure: o_byte_ready drops while the order FIFO is full (and during reset); an offered order is held until the book's busy window ends.
// Ports: i_clk, i_reset_n (sync, active-high), byte input i_byte/i_byte_valid/i_byte_sof/o_byte_ready,
//        i_book_busy, order fields o_trade_type..o_order_id, o_msg_count (wraps), o_err_count (saturates).
module order_feed_parser #(
  parameter int FIFO_DEPTH = 4,
  parameter int MSG_BYTES  = hft_pkg::MSG_BYTES
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  input  logic        i_byte_sof,
  output logic        o_byte_ready,
  input  logic        i_book_busy,
  output logic        o_trade_type,
  output logic [1:0]  o_stock_id,
  output logic [1:0]  o_order_type,
  output logic [15:0] o_quantity,
  output logic [31:0] o_price,
  output logic [31:0] o_order_id,
  output logic [15:0] o_msg_count,
  output logic [7:0]  o_err_count
);

  import hft_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(MSG_BYTES - 1);

  rx_state_t  rx_state;
  logic [3:0] byte_cnt;
  logic [7:0] hdr;
  logic [71:0] body;   // bytes 1..9; byte 10 is taken straight from i_byte at commit

  out_state_t out_state;
  order_msg_t out_q;

  order_msg_t push_msg;
  order_msg_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       last_byte;
  logic       fmt_ok;
  logic       push;
  logic       pop;
  logic       err_inc;

  assign o_byte_ready = !i_reset_n && !fifo_full;
  assign accept       = i_byte_valid && o_byte_ready;
  assign last_byte    = accept && !i_byte_sof && (rx_state == RX_BODY) && (byte_cnt == LAST_IDX);
  assign fmt_ok       = (hdr[4:3] != 2'b11) && (hdr[2:0] == 3'b000);
  assign push         = last_byte && fmt_ok;
  assign pop          = (out_state == OUT_HOLD) && !i_book_busy;

  // Premature sof, stray body byte in idle, or a bad header at commit.
  assign err_inc = accept && ((i_byte_sof && (rx_state == RX_BODY)) ||
                              (!i_byte_sof && (rx_state == RX_IDLE)) ||
                              (last_byte && !fmt_ok));

  always_comb begin
    push_msg            = NOP_MSG;
    push_msg.trade_type = hdr[7];
    push_msg.stock_id   = hdr[6:5];
    push_msg.order_type = order_t'(hdr[4:3]);
    push_msg.quantity   = body[71:56];
    push_msg.price      = body[55:24];
    push_msg.order_id   = {body[23:0], i_byte};
  end

  order_fifo #(
    .WIDTH ($bits(order_msg_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset_n),
    .push      (push),
    .push_data (push_msg),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Receive FSM, field shifter and counters.
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      rx_state    <= RX_IDLE;
      byte_cnt    <= 4'd0;
      hdr         <= 8'd0;
      body        <= 72'd0;
      o_msg_count <= 16'd0;
      o_err_count <= 8'd0;
    end else begin
      if (accept) begin
        if (i_byte_sof) begin
          // A sof always starts a fresh message, whatever state we were in.
          hdr      <= i_byte;
          byte_cnt <= 4'd1;
          rx_state <= RX_BODY;
        end else begin
          case (rx_state)
            RX_IDLE: rx_state <= RX_DROP;
            RX_BODY: begin
              body     <= {body[63:0], i_byte};
              byte_cnt <= byte_cnt + 4'd1;
              if (byte_cnt == LAST_IDX) begin
                rx_state <= RX_IDLE;
              end
            end
            default: rx_state <= RX_DROP;
          endcase
        end
      end
      if (push) begin
        o_msg_count <= o_msg_count + 16'd1;
      end
      if (err_inc && (o_err_count != 8'hFF)) begin
        o_err_count <= o_err_count + 8'd1;
      end
    end
  end

  // Output FSM: offer the head, hold through busy, pop when busy falls.
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      out_state <= OUT_IDLE;
      out_q     <= NOP_MSG;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (!fifo_empty && !i_book_busy) begin
            out_q     <= head;
            out_state <= OUT_PRESENT;
          end
        end
        OUT_PRESENT: begin
          if (i_book_busy) begin
            out_state <= OUT_HOLD;
          end
        end
        OUT_HOLD: begin
          if (!i_book_busy) begin
            out_q     <= NOP_MSG;
            out_state <= OUT_IDLE;
          end
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

  assign o_trade_type = out_q.trade_type;
  assign o_stock_id   = out_q.stock_id;
  assign o_order_type = out_q.order_type;
  assign o_quantity   = out_q.quantity;
  assign o_price      = out_q.price;
  assign o_order_id   = out_q.order_id;

endmodule

// File: tb/tb_order_feed_parser.sv
// Bench for order_feed_parser: scoreboard of expected orders, a simple book model driving busy.
module tb_order_feed_parser;

  logic        i_clk;
  logic        i_reset_n;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        i_byte_sof;
  logic        o_byte_ready;
  logic        i_book_busy;
  logic        o_trade_type;
  logic [1:0]  o_stock_id;
  logic [1:0]  o_order_type;
  logic [15:0] o_quantity;
  logic [31:0] o_price;
  logic [31:0] o_order_id;
  logic [15:0] o_msg_count;
  logic [7:0]  o_err_count;

  order_feed_parser dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .i_byte_sof   (i_byte_sof),
    .o_byte_ready (o_byte_ready),
    .i_book_busy  (i_book_busy),
    .o_trade_type (o_trade_type),
    .o_stock_id   (o_stock_id),
    .o_order_type (o_order_type),
    .o_quantity   (o_quantity),
    .o_price      (o_price),
    .o_order_id   (o_order_id),
    .o_msg_count  (o_msg_count),
    .o_err_count  (o_err_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_msg = 0;
  int exp_err = 0;
  logic [84:0] exp_q[$];
  logic force_busy = 1'b0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Book model and output monitor: compares each newly offered order with the
  // scoreboard, checks the fields stay frozen, and answers with a 3-cycle busy window.
  initial begin : book_monitor
    logic [1:0]  prev_type;
    logic [84:0] held;
    logic [84:0] got;
    logic [84:0] want;
    logic        model_busy;
    int          left;
    prev_type = 2'b11; held = '0; model_busy = 1'b0; left = 0;
    i_book_busy = 1'b0;
    forever begin
      @(negedge i_clk);
      got = {o_trade_type, o_stock_id, o_order_type, o_quantity, o_price, o_order_id};
      if (i_reset_n) begin
        model_busy = 1'b0;
        left = 0;
        prev_type = 2'b11;
      end else begin
        if (model_busy) begin
          left--;
          if (left == 0) model_busy = 1'b0;
        end
        if (o_order_type != 2'b11 && prev_type == 2'b11) begin
          if (exp_q.size() == 0) begin
            check("unexpected_order", got, 85'd0);
          end else begin
            want = exp_q.pop_front();
            check("order", got, want);
          end
          held = got;
          model_busy = 1'b1;
          left = 3;
        end else if (o_order_type != 2'b11) begin
          check("hold_stable", got, held);
        end
        prev_type = o_order_type;
      end
      i_book_busy = model_busy || force_busy;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic sof);
    int n;
    n = 0;
    i_byte = b;
    i_byte_sof = sof;
    i_byte_valid = 1'b1;
    @(negedge i_clk);
    while (!o_byte_ready && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_byte_ready) check("ready_timeout", 96'd0, 96'd1);
    @(posedge i_clk);
    #1;
    i_byte_valid = 1'b0;
    i_byte_sof = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] hdr, input logic [15:0] q, input logic [31:0] p,
                          input logic [31:0] id, input bit valid_fmt);
    logic [87:0] m;
    m = {hdr, q, p, id};
    if (valid_fmt) begin
      exp_q.push_back({hdr[7], hdr[6:5], hdr[4:3], q, p, id});
      exp_msg++;
    end else begin
      exp_err++;
    end
    for (int i = 0; i < 11; i++) send_byte(m[87-8*i -: 8], i == 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge i_clk);
      #2;
      n++;
    end while ((exp_q.size() != 0 || o_order_type != 2'b11 || i_book_busy) && n < 1000);
    check("drain_pending", exp_q.size(), 0);
    check("drain_nop", o_order_type, 2'b11);
  endtask

  task automatic check_reset_values();
    check("rst_ready", o_byte_ready, 1);
    check("rst_type", o_order_type, 2'b11);
    check("rst_fields", {o_trade_type, o_stock_id, o_quantity, o_price, o_order_id}, 0);
    check("rst_msg", o_msg_count, 0);
    check("rst_err", o_err_count, 0);
  endtask

  initial begin : main
    i_reset_n = 1'b1;
    i_byte = 8'd0;
    i_byte_valid = 1'b0;
    i_byte_sof = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("ready_in_reset", o_byte_ready, 0);
    i_reset_n = 1'b0;
    #1;
    check_reset_values();

    // Single ADD, one edge of latency after the last byte.
    send_msg(8'h00, 16'd100, 32'd1000, 32'd42, 1);
    check("lat_before", o_order_type, 2'b11);
    @(posedge i_clk);
    #1;
    check("lat_type", o_order_type, 2'd0);
    check("lat_qty", o_quantity, 16'd100);
    check("lat_price", o_price, 32'd1000);
    check("lat_id", o_order_id, 32'd42);
    wait_idle();
    check("msg_after_add", o_msg_count, exp_msg);

    // Busy book: nothing offered until busy falls, then in order.
    force_busy = 1'b1;
    send_msg(8'hA8, 16'd7, 32'h12345678, 32'hDEADBEEF, 1);
    send_msg(8'h50, 16'hFFFF, 32'hFFFFFFFF, 32'h00000001, 1);
    repeat (5) @(posedge i_clk);
    #1;
    check("busy_nop_type", o_order_type, 2'b11);
    check("busy_nop_fields", {o_trade_type, o_stock_id, o_quantity, o_price, o_order_id}, 0);
    force_busy = 1'b0;
    wait_idle();
    check("msg_after_busy", o_msg_count, exp_msg);

    // FIFO full: ready drops after the 4th commit; the 5th message waits, no loss.
    force_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_msg(8'hE0, 16'(k + 1), 32'(100 * k), 32'(1000 + k), 1);
      check("ready_fill", o_byte_ready, (k < 3) ? 1 : 0);
    end
    fork
      send_msg(8'h30, 16'd55, 32'd66, 32'd77, 1);
      begin
        repeat (10) @(posedge i_clk);
        #2;
        check("ready_held_full", o_byte_ready, 0);
        force_busy = 1'b0;
      end
    join
    wait_idle();
    check("msg_after_full", o_msg_count, exp_msg);

    // Framing: premature sof at byte 5, then stray non-sof bytes in idle.
    send_byte(8'h00, 1);
    for (int k = 1; k < 5; k++) send_byte(8'hAA, 0);
    exp_err++;
    send_msg(8'h48, 16'd300, 32'd400, 32'd500, 1);
    wait_idle();
    check("err_restart", o_err_count, exp_err);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    exp_err++;
    check("err_stray", o_err_count, exp_err);
    send_msg(8'h28, 16'd9, 32'd10, 32'd11, 1);
    wait_idle();
    check("msg_after_framing", o_msg_count, exp_msg);

    // Format errors: order_type 3 and reserved bits set are dropped.
    send_msg(8'h18, 16'd1, 32'd2, 32'd3, 0);
    send_msg(8'h01, 16'd4, 32'd5, 32'd6, 0);
    repeat (5) @(posedge i_clk);
    #1;
    check("fmt_no_offer", o_order_type, 2'b11);
    check("fmt_err", o_err_count, exp_err);
    check("fmt_msg", o_msg_count, exp_msg);

    // Error counter saturation: each back-to-back sof is a premature restart.
    for (int k = 0; k < 300; k++) send_byte(8'h80, 1);
    check("err_saturate", o_err_count, 8'hFF);

    // Reset in the middle of a message.
    send_byte(8'h00, 1);
    for (int k = 1; k < 6; k++) send_byte(8'h11, 0);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("ready_mid_reset", o_byte_ready, 0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    check_reset_values();
    exp_msg = 0;
    exp_err = 0;
    send_msg(8'hC8, 16'd1234, 32'd5678, 32'd9012, 1);
    wait_idle();
    check("msg_after_reset", o_msg_count, exp_msg);
    check("err_after_reset", o_err_count, exp_err);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
